fp_pipe_stage_chain: RTL and testbench
======================================

# fp_pipe_stage_chain

Parametrised pipeline-register chain for the floating-point datapath. It carries the operand pair (X, Y) and a mantissa field through DEPTH register stages. Flow control is a valid/ready handshake with bubble collapsing, a one-entry input skid buffer and a synchronous flush. It replaces fixed single-stage enable registers between FP-unit stages, so stages can stall independently without losing or duplicating beats.

## Interface
- N, default 32: operand width for X and Y.
- M, default 23: mantissa field width.
- DEPTH, default 3: number of pipeline stages; legal range 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous; drops all in-flight beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  chain can accept a beat; driven directly from a register.
- in_x, in_y  in  N each  operand payload.
- in_man  in  M  mantissa payload.
- out_valid  out  1  final stage holds a beat.
- out_ready  in  1  downstream accepts the beat.
- out_x, out_y  out  N each  final-stage payload.
- out_man  out  M  final-stage payload.
- occupancy  out  $clog2(DEPTH+2)  number of valid entries (stages plus skid), 0..DEPTH+1.

## Operation
- State per stage k (0..DEPTH-1):
  - v[k], the valid bit.
  - Payload {x, y, man}.
  - Stage DEPTH-1 drives the out_* ports.
- Skid buffer: sv valid bit plus a payload.
- Reset values:
  - All v[k] = 0 and sv = 0.
  - All payload bits = 0, so out_x, out_y and out_man read 0.
  - in_ready = 1, out_valid = 0, occupancy = 0.
- Advance terms, computed combinationally:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[k] = !v[k] | adv[k+1].
- Stage k>0 with adv[k] = 1 loads v[k] <= v[k-1].
  - The payload is copied only if v[k-1] = 1. On a bubble the payload holds.
- Stage 0 source:
  - The skid buffer when sv = 1.
  - Otherwise in_* when a beat is accepted (acc = in_valid & in_ready).
- Skid buffer behaviour:
  - When acc = 1 and adv[0] = 0, the input beat is captured in skid: sv <= 1.
  - When sv = 1 and adv[0] = 1, skid moves to stage 0: sv <= 0.
  - in_ready = !sv. No combinational path exists from out_ready to in_ready.
- A stage with adv[k] = 0 holds its valid bit and payload unchanged.
- Ordering is strict FIFO. No beat is dropped or duplicated except on flush or reset.
- Flush has priority over all other updates. On a flush cycle:
  - All v[k] and sv are cleared.
  - Any input accepted that cycle is discarded. in_ready still reads !sv for that cycle.
  - Payloads are not cleared.
- occupancy = popcount(v) + sv, combinational from registered bits.

## Timing
- Latency on an empty chain: a beat accepted at edge t is visible at out_* with out_valid = 1 after edge t+DEPTH-1. That is DEPTH cycles from in_valid to out_valid.
- Throughput is 1 beat/cycle with out_ready held high.
- Bubbles collapse: an empty stage accepts even while downstream is stalled.
- With out_ready = 0 continuously, the chain accepts exactly DEPTH+1 beats. in_ready falls the cycle after the skid buffer fills.
- After out_ready returns high:
  - in_ready rises one cycle later, once skid has drained to stage 0.
  - The skid beat is never overtaken.
- out_valid and out_* remain stable while out_valid = 1 and out_ready = 0.
- Simultaneous flush and out_ready = 1: the output beat is treated as consumed. out_valid = 0 the next cycle.
- Asynchronous reset mid-stream returns every output to its reset value immediately, without waiting for a clock edge.

## Test plan
- Reset: assert reset between clock edges -> out_valid = 0, in_ready = 1, occupancy = 0 and out_x = 0 immediately, before the next clk edge.
- Latency, DEPTH=3: single beat in_x = 0x3F800000, in_y = 0x40000000, in_man = 0x000001 at cycle 0 -> out_valid = 1 with identical payload on cycle 3 only.
- Streaming: 16 beats with in_x = i, out_ready = 1 -> outputs i = 0..15 on consecutive cycles with no gaps; occupancy stays at 3 in steady state.
- Backpressure, DEPTH=3, out_ready = 0: offer 6 beats -> 4 accepted; in_ready = 0 afterwards; occupancy = 4. Raise out_ready -> beats 0..3 emerge in order, then beats 4..5, with no loss or duplication.
- Flush: flush with 3 beats in flight and in_valid = 1 -> next cycle out_valid = 0 and occupancy = 0. The beat offered that cycle never appears at the output.
- Reset mid-operation: full chain with out_ready = 0, pulse reset -> all valids clear. A beat sent afterwards emerges after DEPTH cycles with correct payload.

Source files
------------

// File: rtl/fp_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// fp_pipe_stage_chain
//
// Pipeline-register chain that carries an operand pair (X, Y) and a mantissa
// field through DEPTH register stages between floating-point unit stages.
// Flow control is a valid/ready handshake:
//   * Bubbles collapse: an empty stage loads from upstream even while the
//     stages below it are stalled.
//   * A one-entry skid buffer catches the beat accepted in the cycle the chain
//     fills. This lets in_ready come straight from a register, with no
//     combinational path from out_ready.
//   * A synchronous flush drops every in-flight beat, including any beat
//     accepted in the flush cycle itself.
//
// Parameters
//   N      operand width for X and Y
//   M      mantissa field width
//   DEPTH  number of pipeline stages (1..8)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears valids and payloads
//   flush      synchronous; clears all valid bits, payloads are kept
//   in_valid   upstream beat present
//   in_ready   chain can take a beat (registered, equals !skid_valid)
//   in_x/in_y  operand payload, N bits each
//   in_man     mantissa payload, M bits
//   out_valid  final stage holds a beat
//   out_ready  downstream consumes the final-stage beat
//   out_x/out_y/out_man  final-stage payload
//   occupancy  number of valid entries (stages plus skid), 0..DEPTH+1
// ---------------------------------------------------------------------------
module fp_pipe_stage_chain #(
    parameter int N     = 32,
    parameter int M     = 23,
    parameter int DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0]                in_x,
    input  logic [N-1:0]                in_y,
    input  logic [M-1:0]                in_man,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                out_x,
    output logic [N-1:0]                out_y,
    output logic [M-1:0]                out_man,
    output logic [$clog2(DEPTH+2)-1:0]  occupancy
);

    localparam int OW = $clog2(DEPTH + 2);
    // The whole beat travels as one packed word {x, y, man}.
    localparam int PW = 2 * N + M;

    // Stage state
    logic [DEPTH-1:0] v_r;
    logic [PW-1:0]    pl_r [DEPTH];

    // Skid buffer state
    logic             sv_r;
    logic [PW-1:0]    skid_pl_r;

    // in_ready is kept as its own register and always equals !sv_r
    logic             in_ready_r;

    // Combinational helpers
    logic [DEPTH-1:0] adv_s;
    logic             acc_s;
    logic [PW-1:0]    in_pl_s;
    logic             src_v_s;
    logic [PW-1:0]    src_pl_s;
    logic             sv_nxt_s;
    logic [OW-1:0]    occ_s;

    // Advance terms ripple from the output back toward stage 0.
    // A stage may load when it is empty, or when the stage below it also moves.
    always_comb begin
        adv_s            = '0;
        adv_s[DEPTH-1]   = !v_r[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv_s[k] = !v_r[k] | adv_s[k+1];
        end
    end

    // Select the source for stage 0 and compute the next skid-valid bit.
    always_comb begin
        acc_s   = in_valid & in_ready_r;
        in_pl_s = {in_x, in_y, in_man};
        // The skid beat is older than anything on the input, so it has priority.
        // While sv_r is set, in_ready is low and acc_s cannot fire.
        if (sv_r) begin
            src_v_s  = 1'b1;
            src_pl_s = skid_pl_r;
            sv_nxt_s = !adv_s[0];
        end else begin
            src_v_s  = acc_s;
            src_pl_s = in_pl_s;
            sv_nxt_s = acc_s & !adv_s[0];
        end
    end

    // Valid bits, skid valid and the registered in_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_r        <= '0;
            sv_r       <= 1'b0;
            in_ready_r <= 1'b1;
        end else if (flush) begin
            v_r        <= '0;
            sv_r       <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            if (adv_s[0]) begin
                v_r[0] <= src_v_s;
            end else begin
                v_r[0] <= v_r[0];
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv_s[k]) begin
                    v_r[k] <= v_r[k-1];
                end else begin
                    v_r[k] <= v_r[k];
                end
            end
            sv_r       <= sv_nxt_s;
            in_ready_r <= !sv_nxt_s;
        end
    end

    // Payload registers. These load only when a real beat moves in, so a
    // bubble never overwrites them. Flush leaves them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                pl_r[k] <= '0;
            end
            skid_pl_r <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                pl_r[k] <= pl_r[k];
            end
            skid_pl_r <= skid_pl_r;
        end else begin
            if (adv_s[0] && src_v_s) begin
                pl_r[0] <= src_pl_s;
            end else begin
                pl_r[0] <= pl_r[0];
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv_s[k] && v_r[k-1]) begin
                    pl_r[k] <= pl_r[k-1];
                end else begin
                    pl_r[k] <= pl_r[k];
                end
            end
            // Capture into the skid only when the accepted beat cannot enter
            // stage 0 this cycle.
            if (acc_s && !adv_s[0]) begin
                skid_pl_r <= in_pl_s;
            end else begin
                skid_pl_r <= skid_pl_r;
            end
        end
    end

    // Occupancy is a popcount of the registered valid bits plus the skid valid.
    always_comb begin
        occ_s = OW'(sv_r);
        for (int k = 0; k < DEPTH; k++) begin
            occ_s = occ_s + OW'(v_r[k]);
        end
    end

    assign in_ready                  = in_ready_r;
    assign out_valid                 = v_r[DEPTH-1];
    assign {out_x, out_y, out_man}   = pl_r[DEPTH-1];
    assign occupancy                 = occ_s;

endmodule

// File: tb/tb_fp_pipe_stage_chain.sv
// Scoreboard bench for fp_pipe_stage_chain.
// The reference model treats the chain as a FIFO of capacity DEPTH+1:
//   * an accepted beat (valid & ready, no flush, no reset) is pushed;
//   * an output handshake pops the oldest beat and compares it;
//   * flush and reset empty the queue.
// The occupancy and in_ready expectations are derived from the queue size.
module tb_fp_pipe_stage_chain;

    localparam int N     = 32;
    localparam int M     = 23;
    localparam int DEPTH = 3;
    localparam int OW    = $clog2(DEPTH + 2);
    localparam int PW    = 2 * N + M;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_x = '0;
    logic [N-1:0]  in_y = '0;
    logic [M-1:0]  in_man = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_x;
    logic [N-1:0]  out_y;
    logic [M-1:0]  out_man;
    logic [OW-1:0] occupancy;

    int            n_cmp = 0;
    int            n_err = 0;
    int            n_pop = 0;
    bit            chk_en = 1'b0;
    logic [PW-1:0] sb [$];

    fp_pipe_stage_chain #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_man   (out_man),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver helper: inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_beat(input int xval);
        in_x   = N'(xval);
        in_y   = N'($urandom);
        in_man = M'($urandom);
    endtask

    // Stimulus side: record every beat the chain accepts.
    always @(negedge clk) begin
        if (!reset && !flush && in_valid && in_ready) begin
            sb.push_back({in_x, in_y, in_man});
        end
    end

    // Monitor: compare every consumed output beat against the oldest expected beat.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", {out_x, out_y, out_man});
                end else begin
                    check("out_beat", {out_x, out_y, out_man}, sb.pop_front());
                end
            end
            if (flush) begin
                sb.delete();
            end
        end
    end

    // After each edge, occupancy and in_ready must match the FIFO model.
    always @(posedge clk) begin
        #1;
        if (chk_en && !reset) begin
            check("occupancy", occupancy, sb.size());
            check("in_ready", in_ready, (sb.size() < DEPTH + 1));
            if (sb.size() == 0) begin
                check("idle_out_valid", out_valid, 1'b0);
            end
        end
    end

    // Send one beat into an empty chain and measure when it reaches the output.
    task automatic latency_test(input logic [N-1:0] x, input logic [N-1:0] y, input logic [M-1:0] m);
        int lat;
        out_ready = 1'b1;
        in_x = x;
        in_y = y;
        in_man = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, DEPTH - 1);
        check("lat_payload", {out_x, out_y, out_man}, {x, y, m});
        @(posedge clk);
        #1;
        check("lat_one_cycle", out_valid, 1'b0);
        #1;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && w < 60) begin
            tick();
            w++;
        end
        check(name, {out_valid, occupancy}, '0);
    endtask

    // Offer beats with in_x = base+idx until `count` have been accepted or
    // `limit` cycles pass. Returns how many were accepted.
    task automatic offer(input int base, input int count, input int limit, output int acc);
        bit a;
        acc = 0;
        rand_beat(base);
        in_valid = 1'b1;
        for (int c = 0; c < limit && acc < count; c++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #2;
            if (a) begin
                acc++;
                rand_beat(base + acc);
            end
        end
    endtask

    initial begin
        int acc;
        int p0;
        int run;
        int w;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_x", out_x, 0);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        tick();

        // Latency on an empty chain
        latency_test(32'h3F80_0000, 32'h4000_0000, 23'h00_0001);

        // Streaming at full rate
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    in_valid = 1'b1;
                    rand_beat(i);
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                w = 0;
                run = 0;
                while (!out_valid && w < 40) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                while (out_valid && run < 40) begin
                    run++;
                    if (run == 8) begin
                        check("steady_occupancy", occupancy, DEPTH);
                    end
                    @(posedge clk);
                    #1;
                end
                check("stream_no_gaps", run, 16);
            end
        join
        #1;
        drain("stream_drain");

        // Backpressure: chain holds exactly DEPTH+1 beats
        p0 = n_pop;
        out_ready = 1'b0;
        offer(32'h100, 6, 10, acc);
        check("bp_accepted", acc, DEPTH + 1);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_occupancy", occupancy, DEPTH + 1);
        check("bp_out_stable", out_x, 32'h100);
        out_ready = 1'b1;
        // Resume with the beat that was left pending.
        in_x = N'(32'h100 + acc);
        for (int c = 0; c < 30 && acc < 6; c++) begin
            bit a;
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #2;
            if (a) begin
                acc++;
                rand_beat(32'h100 + acc);
            end
        end
        check("bp_all_accepted", acc, 6);
        drain("bp_drain");
        check("bp_beats_out", n_pop - p0, 6);

        // Flush with three beats in flight and a beat offered in the flush cycle
        out_ready = 1'b0;
        offer(32'h200, 3, 10, acc);
        check("fl_setup", acc, 3);
        in_x = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_occupancy", occupancy, 0);
        out_ready = 1'b1;
        p0 = n_pop;
        repeat (8) tick();
        check("fl_no_output", n_pop - p0, 0);

        // Asynchronous reset mid-stream with a full, stalled chain
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_beat(32'h300 + c);
            tick();
        end
        in_valid = 1'b0;
        check("mr_full", occupancy, DEPTH + 1);
        #1;
        reset = 1'b1;
        #1;
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_in_ready", in_ready, 1'b1);
        check("mr_occupancy", occupancy, 0);
        check("mr_payload", {out_x, out_y, out_man}, '0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick();
        latency_test(32'hC0A0_0000, 32'h1234_5678, 23'h55_AA55);

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rand_beat(int'($urandom));
            tick();
        end
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
